// File: rtl/mux16_rr_scheduler_if.sv
// Requester/sink bundle for the 16-lane round-robin bit scheduler.
// master drives requests, data and ready; slave is the scheduler.
interface mux16_rr_scheduler_if;
  logic [15:0] req;
  logic [15:0] din;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out_valid;
  logic        out_bit;
  logic [3:0]  out_src;

  modport master (
    output req, din, out_ready,
    input  sel, gnt, out_valid, out_bit, out_src
  );

  modport slave (
    input  req, din, out_ready,
    output sel, gnt, out_valid, out_bit, out_src
  );
endinterface

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16 requesters,
// with a per-grant beat limit and valid/ready output handshake.
module MUX16to1 (
  input  logic [15:0] d,
  input  logic [3:0]  s,
  output logic        y
);
  assign y = d[s];
endmodule

module mux16_rr_scheduler #(
  parameter int HOLD_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mux16_rr_scheduler_if.slave     bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [3:0]  cnt;
  logic [3:0]  sel;
  logic [15:0] gnt;

  logic        valid;
  logic        xfer;
  logic        last;
  logic        rel;
  logic [3:0]  base;
  logic [3:0]  win;
  logic        win_ok;

  assign valid = (state == GRANT) && bus.req[sel];
  assign xfer  = valid && bus.out_ready;
  assign last  = (cnt == 4'(HOLD_MAX - 1));
  assign rel   = !bus.req[sel] || (xfer && last);

  // On release the search starts just past the current lane,
  // so the released lane is considered last.
  assign base  = (state == GRANT) ? sel + 4'd1 : ptr;

  always_comb begin
    logic [3:0] idx;
    win_ok = 1'b0;
    win    = base;
    idx    = base;
    for (int k = 15; k >= 0; k--) begin
      idx = base + 4'(k);
      if (bus.req[idx]) begin
        win_ok = 1'b1;
        win    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 4'd0;
      cnt   <= 4'd0;
      sel   <= 4'd0;
      gnt   <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            state <= GRANT;
            sel   <= win;
            gnt   <= 16'd1 << win;
            cnt   <= 4'd0;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= sel + 4'd1;
            cnt <= 4'd0;
            if (win_ok) begin
              sel <= win;
              gnt <= 16'd1 << win;
            end else begin
              state <= IDLE;
              gnt   <= 16'd0;
            end
          end else if (xfer) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  MUX16to1 u_mux (
    .d (bus.din),
    .s (sel),
    .y (bus.out_bit)
  );

  assign bus.sel       = sel;
  assign bus.gnt       = gnt;
  assign bus.out_valid = valid;
  assign bus.out_src   = sel;
endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
Round-robin scheduler that shares one 16:1 bit-select datapath between 16 requesters. Each requester presents a data bit on its lane of `din` and raises its `req` bit. The scheduler grants one lane at a time and drives the 4-bit select. It forwards the selected bit downstream through a valid/ready handshake and holds a grant for at most HOLD_MAX beats. It sits between the requester array and the shared output sink, and instantiates MUX16to1 internally for the data path.

Parameters:
HOLD_MAX, 4, maximum accepted beats per grant before forced rotation (legal range 1..15).

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req  input  16  per-lane request; bit i high means lane i has data on din[i]
din  input  16  per-lane data bits; din[i] is valid while req[i] is high
out_ready  input  1  downstream can accept a beat this cycle
sel  output  4  registered select driving MUX16to1; equals the granted lane index
gnt  output  16  registered one-hot grant; all zero when idle
out_valid  output  1  selected beat is valid this cycle
out_bit  output  1  din[sel] through the internal MUX16to1 (combinational from din)
out_src  output  4  lane index of the current beat; always equals sel

Behaviour:
- State machine: IDLE, GRANT. Internal state:
  - `ptr[3:0]`: round-robin start index.
  - `cnt`: beats accepted under the current grant.
- Reset, sampled on a clk edge with rst=1:
  - state=IDLE, ptr=0, cnt=0, sel=0, gnt=0.
  - out_valid=0; out_bit follows din[0].
  - Reset overrides everything, including an in-progress grant; no beat is accepted in the reset cycle.
- Arbitration function: first i in order ptr, ptr+1, ..., ptr+15 (mod 16) with req[i]=1.
- IDLE:
  - If req != 0: on the next edge sel=winner, gnt=1<<winner, cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
  - Latency: request seen at edge t gives gnt/sel/out_valid at t+1.
- GRANT:
  - out_valid = req[sel] (combinational). A transfer occurs when out_valid && out_ready.
  - Transfer: cnt increments.
  - Release condition, evaluated each GRANT cycle: (req[sel]==0) OR (transfer AND cnt==HOLD_MAX-1).
  - On release: ptr = sel+1 (mod 16, so 15 wraps to 0), and arbitration runs in the same cycle using the new ptr and current req.
    - If a winner exists, the next edge loads the new sel/gnt with cnt=0 and stays in GRANT. Back-to-back, no idle bubble.
    - If no winner, go to IDLE with gnt=0.
  - The released lane is searched last, so it is re-granted only if it is the sole requester.
  - No release (req[sel]=1 and the hold limit is not reached): sel, gnt and ptr are unchanged.
  - A stall (out_ready=0) holds the grant indefinitely; cnt does not advance.
- Requester withdrawal: a lane dropping req while granted produces no beat that cycle (out_valid=0) and causes a release.
- out_bit is don't-care when out_valid=0.
- gnt is always one-hot or zero; sel never changes while out_valid=1 and out_ready=0.

Test Plan:
1. Single lane, bit pattern: din=16'h3f0a, req=16'h0002, out_ready=1, HOLD_MAX=4.
   - Cycle after req: sel=1, gnt=16'h0002, out_valid=1, out_bit=1.
   - After 4 beats, lane 1 is re-granted with ptr=2.
   - cnt restarts; beats continue uninterrupted.
2. Round-robin rotation: din=16'h3f0a, req=16'h1041 (lanes 0, 6, 12) held, out_ready=1.
   - Grants go 0, 6, 12, 0 in 4-beat bursts.
   - out_bit is 0, 0, 1 for lanes 0, 6, 12 respectively.
   - No idle cycle between bursts.
3. Backpressure: lane 12 granted, out_ready=0 for 10 cycles, then 1.
   - sel stays 12 and out_valid stays 1 throughout the stall.
   - cnt stays 0; exactly 4 beats complete after out_ready rises.
4. Withdrawal and wrap: ptr=15, req=16'h8001; lane 15 is granted.
   - Drop req[15] after 2 beats: out_valid=0 that cycle.
   - Next edge: sel=0, gnt=16'h0001, ptr wrapped to 0.
5. Idle return and reset: req drops to 0 → next edge state IDLE, gnt=0, out_valid=0.
   - Separately, assert rst mid-burst on lane 6: next edge sel=0, gnt=0, out_valid=0, ptr=0.
   - After rst deasserts with req=16'h0040, lane 6 is granted one cycle later.
